id_ex_stage: RTL and testbench

//   ID/EX pipeline register plus EX-stage operand forwarding, sitting directly upstream of the alu.

---
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from MEM and WB.
// Drives the alu operand ports and carries destination/store data downstream.
module id_ex_stage #(
    parameter int WIDTH          = 32,
    parameter int CTRL_WIDTH     = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [CTRL_WIDTH-1:0]     id_alu_control,
    input  logic                      id_alu_src,
    input  logic                      id_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [WIDTH-1:0]          id_rs1_data,
    input  logic [WIDTH-1:0]          id_rs2_data,
    input  logic [WIDTH-1:0]          id_imm,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]          mem_result,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [WIDTH-1:0]          wb_result,
    output logic                      ex_valid,
    output logic [CTRL_WIDTH-1:0]     alu_control,
    output logic [WIDTH-1:0]          a,
    output logic [WIDTH-1:0]          b,
    output logic [WIDTH-1:0]          store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write
);

    logic                      valid_q;
    logic [CTRL_WIDTH-1:0]     alu_control_q;
    logic                      alu_src_q;
    logic                      reg_write_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic [WIDTH-1:0]          rs1_data_q;
    logic [WIDTH-1:0]          rs2_data_q;
    logic [WIDTH-1:0]          imm_q;
    logic [WIDTH-1:0]          fwd_rs1;
    logic [WIDTH-1:0]          fwd_rs2;

    // MEM beats WB; x0 always reads the registered value.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_reg_write && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
            fwd_rs1 = wb_result;

        fwd_rs2 = rs2_data_q;
        if (mem_reg_write && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
            fwd_rs2 = wb_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
        end else if (flush) begin
            valid_q       <= 1'b0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
        end else if (stall) begin
            // Capture forwarded values so a hit survives the producer retiring while held.
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
        end else begin
            valid_q       <= id_valid;
            alu_control_q <= id_alu_control;
            alu_src_q     <= id_alu_src;
            reg_write_q   <= id_reg_write & id_valid;
            rs1_addr_q    <= id_rs1_addr;
            rs2_addr_q    <= id_rs2_addr;
            rd_addr_q     <= id_rd_addr;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_control  = alu_control_q;
    assign a            = fwd_rs1;
    assign b            = alu_src_q ? imm_q : fwd_rs2;
    assign store_data   = fwd_rs2;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: capture, forwarding priority, x0, stall, flush, reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid, id_alu_src, id_reg_write;
    logic [2:0]  id_alu_control;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid, ex_reg_write;
    logic [2:0]  alu_control;
    logic [31:0] a, b, store_data;
    logic [4:0]  ex_rd_addr;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.WIDTH(32), .CTRL_WIDTH(3), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
        .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
        .wb_result(wb_result), .ex_valid(ex_valid), .alu_control(alu_control), .a(a), .b(b),
        .store_data(store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [2:0] ctrl, input logic src, input logic rw,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        id_valid = v; id_alu_control = ctrl; id_alu_src = src; id_reg_write = rw;
        id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    task automatic idle_fwd();
        mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
        wb_reg_write  = 1'b0; wb_rd_addr  = '0; wb_result  = '0;
    endtask

    // Advance past the next rising edge and settle outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        idle_fwd();
        #12;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst_alu_control", {29'd0, alu_control}, 32'd0);
        check("rst_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
        check("rst_a", a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ADD x5 = x3 + x4
        drive_id(1'b1, 3'b000, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 32'd5, 32'd7, 32'd0);
        step();
        check("load_a", a, 32'd5);
        check("load_b", b, 32'd7);
        check("load_valid", {31'd0, ex_valid}, 32'd1);
        check("load_reg_write", {31'd0, ex_reg_write}, 32'd1);
        check("load_rd", {27'd0, ex_rd_addr}, 32'd5);
        check("load_store_data", store_data, 32'd7);

        // Forwarding is combinational on the held instruction
        @(negedge clk);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h10;
        wb_reg_write  = 1'b1; wb_rd_addr  = 5'd3; wb_result  = 32'h20;
        #1 check("fwd_mem_priority", a, 32'h10);
        check("fwd_b_untouched", b, 32'd7);
        mem_reg_write = 1'b0;
        #1 check("fwd_wb", a, 32'h20);
        wb_rd_addr = 5'd4;
        #1 check("fwd_wb_rs2", b, 32'h20);
        check("fwd_wb_rs1_clear", a, 32'd5);
        idle_fwd();

        // x0 is never forwarded
        drive_id(1'b1, 3'b001, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0);
        step();
        @(negedge clk);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 32'hFF;
        wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 32'hEE;
        #1 check("x0_a", a, 32'd0);
        check("x0_b", b, 32'd0);
        idle_fwd();

        // Stall captures a MEM hit on rs2 that then retires
        drive_id(1'b1, 3'b010, 1'b0, 1'b1, 5'd1, 5'd6, 5'd7, 32'd1, 32'd2, 32'd0);
        step();
        @(negedge clk);
        stall = 1'b1;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd6; mem_result = 32'hAB;
        drive_id(1'b1, 3'b011, 1'b0, 1'b1, 5'd2, 5'd8, 5'd10, 32'h11, 32'h99, 32'd0);
        #1 check("stall_fwd_b", b, 32'hAB);
        @(negedge clk);
        idle_fwd();
        #1 check("stall_held_b", b, 32'hAB);
        check("stall_held_ctrl", {29'd0, alu_control}, 32'd2);
        check("stall_held_rd", {27'd0, ex_rd_addr}, 32'd7);
        check("stall_held_a", a, 32'd1);
        step();
        check("stall_held_b2", b, 32'hAB);

        // Flush wins over stall
        @(negedge clk);
        flush = 1'b1;
        step();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("flush_ctrl", {29'd0, alu_control}, 32'd0);
        check("flush_rd", {27'd0, ex_rd_addr}, 32'd0);
        check("flush_a", a, 32'd0);
        @(negedge clk);
        flush = 1'b0; stall = 1'b0;

        // Immediate operand with forwarded store data
        drive_id(1'b1, 3'b000, 1'b1, 1'b0, 5'd2, 5'd4, 5'd0, 32'd3, 32'd7, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 32'd9;
        #1 check("imm_b", b, 32'hFFFF_FFFC);
        check("imm_store_data", store_data, 32'd9);
        check("imm_reg_write", {31'd0, ex_reg_write}, 32'd0);
        idle_fwd();

        // Invalid slot never writes
        drive_id(1'b0, 3'b101, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
        step();
        check("bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);

        // Asynchronous reset mid-cycle
        drive_id(1'b1, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
        step();
        check("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", {31'd0, ex_valid}, 32'd0);
        check("async_rst_ctrl", {29'd0, alu_control}, 32'd0);
        check("async_rst_reg_write", {31'd0, ex_reg_write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
